// File: rtl/write_ascii_lcd.sv
// HD44780 8-bit character-entry front end: power-up init, debounced button press writes data_btn as a character.
// Latency: E pulse 6 edges after a clean press when idle; backpressure: one pending press slot, further presses dropped.
module write_ascii_lcd #(
   parameter int CHARS_PER_LINE = 16,
   parameter int PWRUP_CYCLES   = 16
) (
   input  logic       clk_1024,
   input  logic       reset_n,
   input  logic       debounce_en,
   input  logic       button,
   input  logic [7:0] data_btn,
   output logic [7:0] data_btn_lcd,
   output logic       E_btn_lcd,
   output logic       RW_btn_lcd,
   output logic       RS_btn_lcd
);

   localparam int CW = $clog2(2 * CHARS_PER_LINE + 1);
   localparam int PW = $clog2(PWRUP_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_PWRUP, ST_INIT, ST_IDLE, ST_WRITE_CHAR, ST_WRITE_ADDR
   } state_t;

   typedef enum logic [2:0] {
      PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT, PH_WAIT2
   } phase_t;

   state_t        state, state_nxt;
   phase_t        phase, phase_nxt;
   logic [PW-1:0] pwr_cnt, pwr_cnt_nxt;
   logic [1:0]    init_idx, init_idx_nxt;
   logic [CW-1:0] char_cnt, char_cnt_nxt, char_inc;

   logic [2:0]    s;
   logic          deb, deb_d, press;
   logic          pending;
   logic [7:0]    latch;
   logic [7:0]    lcd_data;
   logic          lcd_rs;

   logic          busy, is_clear, trans_done;
   logic          load, load_rs, take_char;
   logic [7:0]    load_dat;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   endfunction

   // Debounce: level only moves after three agreeing enabled samples.
   always_ff @(posedge clk_1024) begin
      if (!reset_n) begin
         s       <= 3'b000;
         deb     <= 1'b0;
         deb_d   <= 1'b0;
         pending <= 1'b0;
         latch   <= 8'h00;
      end else begin
         if (debounce_en)
            s <= {s[1:0], button};
         if (s == 3'b111)
            deb <= 1'b1;
         else if (s == 3'b000)
            deb <= 1'b0;
         deb_d <= deb;
         if (take_char)
            pending <= 1'b0;
         else if (press && !pending) begin
            pending <= 1'b1;
            latch   <= data_btn;
         end
      end
   end

   assign press      = deb & ~deb_d;
   assign busy       = (state == ST_INIT) || (state == ST_WRITE_CHAR) || (state == ST_WRITE_ADDR);
   assign is_clear   = (state == ST_INIT) && (init_idx == 2'd2);
   assign trans_done = ((phase == PH_WAIT) && !is_clear) || (phase == PH_WAIT2);
   assign char_inc   = char_cnt + 1'b1;

   always_ff @(posedge clk_1024) begin
      if (!reset_n) begin
         state    <= ST_PWRUP;
         phase    <= PH_SETUP;
         pwr_cnt  <= '0;
         init_idx <= 2'd0;
         char_cnt <= '0;
         lcd_data <= 8'h00;
         lcd_rs   <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         pwr_cnt  <= pwr_cnt_nxt;
         init_idx <= init_idx_nxt;
         char_cnt <= char_cnt_nxt;
         if (load) begin
            lcd_data <= load_dat;
            lcd_rs   <= load_rs;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      pwr_cnt_nxt  = pwr_cnt;
      init_idx_nxt = init_idx;
      char_cnt_nxt = char_cnt;
      load         = 1'b0;
      load_rs      = 1'b0;
      load_dat     = 8'h00;
      take_char    = 1'b0;

      if (busy) begin
         case (phase)
            PH_SETUP: phase_nxt = PH_PULSE;
            PH_PULSE: phase_nxt = PH_HOLD;
            PH_HOLD:  phase_nxt = PH_WAIT;
            PH_WAIT:  phase_nxt = is_clear ? PH_WAIT2 : PH_SETUP;
            default:  phase_nxt = PH_SETUP;
         endcase
      end

      // A transaction ending in WAIT may load the next one so its SETUP follows with no gap.
      case (state)
         ST_PWRUP: begin
            if (pwr_cnt == PW'(PWRUP_CYCLES - 1)) begin
               state_nxt    = ST_INIT;
               phase_nxt    = PH_SETUP;
               init_idx_nxt = 2'd0;
               load         = 1'b1;
               load_dat     = init_cmd(2'd0);
            end else begin
               pwr_cnt_nxt = pwr_cnt + 1'b1;
            end
         end
         ST_INIT: begin
            if (trans_done) begin
               if (init_idx == 2'd3) begin
                  state_nxt = ST_IDLE;
               end else begin
                  init_idx_nxt = init_idx + 1'b1;
                  load         = 1'b1;
                  load_dat     = init_cmd(init_idx + 1'b1);
               end
            end
         end
         ST_IDLE: begin
            if (pending) begin
               state_nxt = ST_WRITE_CHAR;
               phase_nxt = PH_SETUP;
               load      = 1'b1;
               load_rs   = 1'b1;
               load_dat  = latch;
               take_char = 1'b1;
            end
         end
         ST_WRITE_CHAR: begin
            if (trans_done) begin
               if (char_inc == CW'(CHARS_PER_LINE)) begin
                  state_nxt    = ST_WRITE_ADDR;
                  load         = 1'b1;
                  load_dat     = 8'hC0;
                  char_cnt_nxt = char_inc;
               end else if (char_inc == CW'(2 * CHARS_PER_LINE)) begin
                  state_nxt    = ST_WRITE_ADDR;
                  load         = 1'b1;
                  load_dat     = 8'h80;
                  char_cnt_nxt = '0;
               end else begin
                  state_nxt    = ST_IDLE;
                  char_cnt_nxt = char_inc;
               end
            end
         end
         ST_WRITE_ADDR: begin
            if (trans_done)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_PWRUP;
      endcase
   end

   always_comb begin
      E_btn_lcd    = busy && (phase == PH_PULSE);
      RW_btn_lcd   = 1'b0;
      data_btn_lcd = lcd_data;
      RS_btn_lcd   = lcd_rs;
   end

endmodule

// File: tb/tb_write_ascii_lcd.sv
// Bench for write_ascii_lcd: records every LCD transaction on the E strobe and compares against a transaction-level model.
module tb_write_ascii_lcd;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       debounce_en = 1'b1;
   logic       button = 1'b0;
   logic [7:0] data_btn = 8'h00;
   logic [7:0] data_btn_lcd;
   logic       E_btn_lcd, RW_btn_lcd, RS_btn_lcd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] got_dat[$];
   logic       got_rs[$];
   int         got_cyc[$];
   logic [8:0] exp_q[$];
   bit         e_prev = 1'b0;
   bit         e_long = 1'b0;
   bit         rw_seen = 1'b0;

   write_ascii_lcd #(.CHARS_PER_LINE(16), .PWRUP_CYCLES(16)) dut (
      .clk_1024    (clk),
      .reset_n     (reset_n),
      .debounce_en (debounce_en),
      .button      (button),
      .data_btn    (data_btn),
      .data_btn_lcd(data_btn_lcd),
      .E_btn_lcd   (E_btn_lcd),
      .RW_btn_lcd  (RW_btn_lcd),
      .RS_btn_lcd  (RS_btn_lcd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Transaction monitor: one record per rising E, stamped with the edge count that raised it.
   always @(negedge clk) begin
      if (E_btn_lcd === 1'b1 && e_prev) e_long = 1'b1;
      if (E_btn_lcd === 1'b1 && !e_prev) begin
         got_dat.push_back(data_btn_lcd);
         got_rs.push_back(RS_btn_lcd);
         got_cyc.push_back(cyc);
      end
      if (RW_btn_lcd === 1'b1) rw_seen = 1'b1;
      e_prev = (E_btn_lcd === 1'b1);
   end

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      got_dat.delete();
      got_rs.delete();
      got_cyc.delete();
   endtask

   task automatic do_reset(output int rel);
      reset_n = 1'b0;
      button  = 1'b0;
      step(3);
      reset_n = 1'b1;
      rel = cyc;
      clear_log();
   endtask

   task automatic wait_pulses(input int n, input int budget);
      for (int k = 0; k < budget && got_dat.size() < n; k++) step();
   endtask

   task automatic test_reset();
      int rel;
      reset_n = 1'b0;
      step(3);
      n_checks++;
      if (data_btn_lcd !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_btn_lcd); end
      n_checks++;
      if (E_btn_lcd !== 1'b0) begin n_fail++; $display("FAIL reset_e got %b want 0", E_btn_lcd); end
      n_checks++;
      if (RS_btn_lcd !== 1'b0) begin n_fail++; $display("FAIL reset_rs got %b want 0", RS_btn_lcd); end
      n_checks++;
      if (RW_btn_lcd !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %b want 0", RW_btn_lcd); end
      reset_n = 1'b1;
      rel = cyc;
      clear_log();
      wait_pulses(1, 40);
      n_checks++;
      if (got_dat.size() < 1) begin
         n_fail++; $display("FAIL reset_first_pulse got none want one within 40 cycles");
      end else begin
         if (got_cyc[0] - rel != 17) begin n_fail++; $display("FAIL reset_first_latency got %0d want 17", got_cyc[0] - rel); end
         n_checks++;
         if (got_dat[0] !== 8'h38 || got_rs[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_cmd got rs=%b %h want rs=0 38", got_rs[0], got_dat[0]);
         end
      end
   endtask

   task automatic test_init();
      int rel;
      logic [7:0] cmds[4];
      int offs[4];
      cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
      offs = '{17, 21, 25, 30};
      do_reset(rel);
      wait_pulses(4, 60);
      n_checks++;
      if (got_dat.size() != 4) begin
         n_fail++; $display("FAIL init_count got %0d want 4", got_dat.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_dat[i] !== cmds[i] || got_rs[i] !== 1'b0) begin
               n_fail++; $display("FAIL init_cmd%0d got rs=%b %h want rs=0 %h", i, got_rs[i], got_dat[i], cmds[i]);
            end
            n_checks++;
            if (got_cyc[i] - rel != offs[i]) begin
               n_fail++; $display("FAIL init_time%0d got %0d want %0d", i, got_cyc[i] - rel, offs[i]);
            end
         end
      end
      step(rel + 60 - cyc);
      n_checks++;
      if (got_dat.size() != 4) begin n_fail++; $display("FAIL init_quiet got %0d pulses want 4", got_dat.size()); end
   endtask

   task automatic test_early_press();
      int rel, c0;
      debounce_en = 1'b1;
      data_btn = 8'h00;
      do_reset(rel);
      step();
      button = 1'b1;
      step(50);
      button = 1'b0;
      n_checks++;
      if (got_dat.size() != 5) begin
         n_fail++; $display("FAIL early_count got %0d want 5", got_dat.size());
      end else begin
         if (got_dat[4] !== 8'h00 || got_rs[4] !== 1'b1) begin
            n_fail++; $display("FAIL early_data got rs=%b %h want rs=1 00", got_rs[4], got_dat[4]);
         end
         n_checks++;
         if (got_cyc[4] - rel != 35) begin n_fail++; $display("FAIL early_time got %0d want 35", got_cyc[4] - rel); end
      end
      step(50);
      data_btn = 8'h02;
      button = 1'b1;
      c0 = cyc;
      step(20);
      button = 1'b0;
      step(20);
      n_checks++;
      if (got_dat.size() != 6) begin
         n_fail++; $display("FAIL second_count got %0d want 6", got_dat.size());
      end else begin
         if (got_dat[5] !== 8'h02 || got_rs[5] !== 1'b1) begin
            n_fail++; $display("FAIL second_data got rs=%b %h want rs=1 02", got_rs[5], got_dat[5]);
         end
         n_checks++;
         if (got_cyc[5] - c0 != 7) begin n_fail++; $display("FAIL second_latency got %0d want 7", got_cyc[5] - c0); end
      end
   endtask

   task automatic test_bounce();
      int n0;
      n0 = got_dat.size();
      debounce_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         button = ~button;
         step();
      end
      button = 1'b0;
      step(10);
      button = 1'b1;
      step(2);
      button = 1'b0;
      step(10);
      n_checks++;
      if (got_dat.size() != n0) begin n_fail++; $display("FAIL bounce got %0d pulses want %0d", got_dat.size(), n0); end
      debounce_en = 1'b0;
      button = 1'b1;
      step(20);
      button = 1'b0;
      step();
      debounce_en = 1'b1;
      step(10);
      n_checks++;
      if (got_dat.size() != n0) begin n_fail++; $display("FAIL frozen got %0d pulses want %0d", got_dat.size(), n0); end
   endtask

   task automatic test_mid_reset();
      int rel, k;
      data_btn = 8'h55;
      button = 1'b1;
      step(4);
      button = 1'b0;
      for (k = 0; k < 20 && E_btn_lcd !== 1'b1; k++) step();
      n_checks++;
      if (E_btn_lcd !== 1'b1) begin
         n_fail++; $display("FAIL midreset_pulse got E=%b want 1 within 20 cycles", E_btn_lcd);
      end else begin
         reset_n = 1'b0;
         step();
         n_checks++;
         if (E_btn_lcd !== 1'b0 || data_btn_lcd !== 8'h00 || RS_btn_lcd !== 1'b0) begin
            n_fail++; $display("FAIL midreset_abort got E=%b rs=%b %h want 0 0 00", E_btn_lcd, RS_btn_lcd, data_btn_lcd);
         end
         step();
         reset_n = 1'b1;
         rel = cyc;
         clear_log();
         wait_pulses(4, 50);
         n_checks++;
         if (got_dat.size() != 4) begin
            n_fail++; $display("FAIL midreset_init_count got %0d want 4", got_dat.size());
         end else begin
            if ({got_dat[0], got_dat[1], got_dat[2], got_dat[3]} !== 32'h380C0106) begin
               n_fail++; $display("FAIL midreset_init_seq got %h %h %h %h want 38 0c 01 06",
                                  got_dat[0], got_dat[1], got_dat[2], got_dat[3]);
            end
            n_checks++;
            if (got_cyc[0] - rel != 17) begin n_fail++; $display("FAIL midreset_latency got %0d want 17", got_cyc[0] - rel); end
         end
      end
   endtask

   task automatic test_line_wrap();
      int rel, cnt;
      logic [7:0] d;
      do_reset(rel);
      debounce_en = 1'b1;
      step(40);
      exp_q.delete();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
      cnt = 0;
      for (int i = 0; i < 34; i++) begin
         d = 8'($urandom_range(0, 255));
         data_btn = d;
         button = 1'b1;
         step($urandom_range(4, 8));
         button = 1'b0;
         step($urandom_range(12, 18));
         exp_q.push_back({1'b1, d});
         cnt++;
         if (cnt == 16) exp_q.push_back({1'b0, 8'hC0});
         else if (cnt == 32) begin
            exp_q.push_back({1'b0, 8'h80});
            cnt = 0;
         end
      end
      step(30);
      n_checks++;
      if (got_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL wrap_count got %0d want %0d", got_dat.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ({got_rs[i], got_dat[i]} !== exp_q[i]) begin
               n_fail++; $display("FAIL wrap_txn%0d got rs=%b %h want rs=%b %h", i, got_rs[i], got_dat[i], exp_q[i][8], exp_q[i][7:0]);
            end
         end
         n_checks++;
         if (got_dat[20] !== 8'hC0 || got_rs[20] !== 1'b0) begin
            n_fail++; $display("FAIL wrap_line2 got rs=%b %h want rs=0 c0", got_rs[20], got_dat[20]);
         end
         n_checks++;
         if (got_dat[37] !== 8'h80 || got_rs[37] !== 1'b0) begin
            n_fail++; $display("FAIL wrap_line1 got rs=%b %h want rs=0 80", got_rs[37], got_dat[37]);
         end
      end
      n_checks++;
      if (e_long) begin n_fail++; $display("FAIL e_width got multi-cycle E want single-cycle"); end
      n_checks++;
      if (rw_seen) begin n_fail++; $display("FAIL rw got 1 want 0"); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_early_press();
      test_bounce();
      test_mid_reset();
      test_line_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/write_ascii_lcd.md
# write_ascii_lcd

Character-entry front end for an HD44780-compatible 8-bit parallel LCD. It initialises the display after reset, debounces a push-button and, on every debounced press, writes the 8-bit ASCII code on `data_btn` to the display as a data character. It advances the cursor across two 16-character lines. The block sits between the board's switch/button inputs and the LCD connector and runs from the slow 1024 Hz system clock.

## Interface
- `CHARS_PER_LINE`, 16: characters per display line before the cursor jumps to the next line.
- `PWRUP_CYCLES`, 16: clock cycles to wait after reset before the first command (≥15 ms at 1024 Hz).
- `clk_1024`  in  1  system clock, 1024 Hz; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `debounce_en`  in  1  debounce sample strobe; the button is sampled only on edges where this is 1.
- `button`  in  1  raw push-button, active high.
- `data_btn`  in  8  ASCII code to write on a press.
- `data_btn_lcd`  out  8  LCD DB7..DB0.
- `E_btn_lcd`  out  1  LCD enable strobe.
- `RW_btn_lcd`  out  1  LCD R/W; always 0 (write only, busy flag never read).
- `RS_btn_lcd`  out  1  LCD register select: 0 = command, 1 = data.

## Operation
- **Reset** (`reset_n`=0 at an edge): state PWRUP, wait counter 0, debounce shift register 000, debounced level 0, pending flag 0, char counter 0.
  - Outputs during reset: `data_btn_lcd`=0x00, `E_btn_lcd`=0, `RW_btn_lcd`=0, `RS_btn_lcd`=0.
  - Reset mid-transaction aborts it immediately and restarts power-up.
- **Debounce**
  - 3-bit shift register `s` shifts in `button` on edges with `debounce_en`=1; it holds otherwise.
  - Debounced level `deb` is a register: set to 1 when `s`=111, cleared when `s`=000, held otherwise.
  - Press event = `deb`=1 and its one-cycle-delayed copy = 0.
- **Press capture**
  - On a press event: pending←1 and char latch←`data_btn` at that edge.
  - One pending slot only. A press while pending=1 is dropped and the latch is not overwritten.
  - Presses during PWRUP/INIT are captured and serviced after init.
- **FSM states**: PWRUP → INIT → IDLE ↔ WRITE_CHAR → (optional) WRITE_ADDR → IDLE.
  - PWRUP: count `PWRUP_CYCLES`, then go to INIT.
  - INIT: issue commands 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (increment, no shift), in that order, with RS=0.
  - IDLE: if pending, start a data transaction (RS=1, data = latch) and clear pending when it starts.
  - After a data write the char counter increments.
    - When it reaches `CHARS_PER_LINE`, issue command 0xC0 (line 2 start).
    - When it reaches 2×`CHARS_PER_LINE`, issue 0x80 (line 1 start) and reset the counter to 0; subsequent characters overwrite the display.
- **Transaction sequencer** (shared by commands and data), one state per cycle:
  - SETUP: RS/data driven, E=0.
  - PULSE: E=1.
  - HOLD: E=0, RS/data unchanged.
  - WAIT: 1 cycle, or 2 cycles after 0x01.
- `data_btn_lcd` and `RS_btn_lcd` hold their last value between transactions. `E_btn_lcd` is high only in PULSE.

## Timing
- Normal transaction: 4 cycles SETUP→end of WAIT. Clear: 5 cycles. The next transaction's SETUP follows immediately.
- Init complete (IDLE reached) `PWRUP_CYCLES`+17 = 33 cycles after the first edge with `reset_n`=1.
- Button latency, with `button`=1 before edge N and `debounce_en`=1 held:
  - `s`=111 after edge N+2.
  - `deb`=1 after N+3.
  - pending/latch at N+4.
  - SETUP at N+5 if IDLE.
  - E high during the cycle after N+6.
- A glitch shorter than 3 `debounce_en` samples produces no press. A release requires 3 zero samples before another press can register.
- `debounce_en`=0 freezes `s`, so no press or release can register.
- Exactly one E pulse per LCD transaction. RW never asserted.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles → all outputs 0. After release, first E pulse comes 17 cycles later with data 0x38, RS=0.
- Init sequence: release reset, count E pulses → 0x38, 0x0C, 0x01, 0x06, all RS=0; 4/4/5/4-cycle spacing; idle by cycle 33.
- Early press: `debounce_en`=1, `data_btn`=0x00, `button`=1 one cycle after reset release for 50 cycles → after init, one data write 0x00 with RS=1. Then `button`=0 for 50 cycles, `data_btn`=0x02, `button`=1 → second write 0x02, RS=1.
- Bounce rejection: `button` toggling every cycle for 20 cycles → no E pulse after init.
- Line wrap: 16 presses → after the 16th data write, command 0xC0 follows. After 32 presses, 0x80 follows and the counter restarts.
- Mid-op reset: assert `reset_n`=0 during PULSE → next edge E=0, data=0x00, and the full init sequence repeats.
